// File: rtl/axil_stream_reader.sv
// AXI4-Lite poller: reads a remote FIFO's count register, then drains up to MAX_BURST words
// from its data register onto AXI-Stream. Define AXIL_STREAM_READER_ERR_COUNT_EN to add err_count.
module axil_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int BASE_ADDR  = 0,
    parameter int MAX_BURST  = 16,
    parameter int POLL_GAP   = 8
) (
    input  logic                  M_AXI_ACLK,
    input  logic                  M_AXI_ARESETN,
    input  logic                  enable,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY,
    output logic                  M_AXIS_TVALID,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    input  logic                  M_AXIS_TREADY,
`ifdef AXIL_STREAM_READER_ERR_COUNT_EN
    output logic [15:0]           err_count,
`endif
    output logic                  busy
);

    // state    | meaning
    // IDLE     | waiting for enable
    // CNT_AR   | read address phase for the count register
    // CNT_R    | waiting for the count value
    // DAT_AR   | read address phase for the data register
    // DAT_R    | waiting for a data word
    // OUT      | presenting the word on the stream port
    // GAP      | back-off after an empty or failed poll
    typedef enum logic [2:0] {
        S_IDLE, S_CNT_AR, S_CNT_R, S_DAT_AR, S_DAT_R, S_OUT, S_GAP
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_DATA = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CNT  = ADDR_WIDTH'(BASE_ADDR + 4);
    localparam logic [9:0]            BURST_MAX = 10'(MAX_BURST);
    localparam logic [7:0]            GAP_LOAD  = 8'(POLL_GAP - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [9:0]              r_remaining;
    logic [7:0]              r_gap_cnt;
    logic [DATA_WIDTH-1:0]   r_tdata;

    logic                    w_r_ok;
    logic [9:0]              w_cnt_field;
    logic                    w_cnt_empty;
    logic [9:0]              w_burst;
    logic                    w_last;
    logic                    w_consume;

    assign w_r_ok      = (M_AXI_RRESP == 2'b00);
    assign w_cnt_field = M_AXI_RDATA[9:0];
    assign w_cnt_empty = ~w_r_ok | (w_cnt_field == 10'd0);
    assign w_burst     = (w_cnt_field > BURST_MAX) ? BURST_MAX : w_cnt_field;
    // "last" means remaining will hit zero after the current word is retired
    assign w_last      = (r_remaining <= 10'd1);
    assign w_consume   = ((r_state == S_DAT_R) && M_AXI_RVALID && !w_r_ok) ||
                         ((r_state == S_OUT) && M_AXIS_TREADY);

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (enable) w_state_nxt = S_CNT_AR;
            S_CNT_AR: if (M_AXI_ARREADY) w_state_nxt = S_CNT_R;
            S_CNT_R:  if (M_AXI_RVALID) w_state_nxt = w_cnt_empty ? S_GAP : S_DAT_AR;
            S_DAT_AR: if (M_AXI_ARREADY) w_state_nxt = S_DAT_R;
            S_DAT_R: begin
                if (M_AXI_RVALID) begin
                    if (w_r_ok)      w_state_nxt = S_OUT;
                    else if (w_last) w_state_nxt = S_IDLE;
                    else             w_state_nxt = S_DAT_AR;
                end
            end
            S_OUT:    if (M_AXIS_TREADY) w_state_nxt = w_last ? S_IDLE : S_DAT_AR;
            S_GAP:    if (r_gap_cnt == 8'd0) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        M_AXI_ARVALID = 1'b0;
        M_AXI_ARADDR  = '0;
        M_AXI_RREADY  = 1'b0;
        M_AXIS_TVALID = 1'b0;
        busy          = (r_state != S_IDLE);
        case (r_state)
            S_CNT_AR: begin
                M_AXI_ARVALID = 1'b1;
                M_AXI_ARADDR  = ADDR_CNT;
            end
            S_DAT_AR: begin
                M_AXI_ARVALID = 1'b1;
                M_AXI_ARADDR  = ADDR_DATA;
            end
            S_CNT_R, S_DAT_R: M_AXI_RREADY  = 1'b1;
            S_OUT:            M_AXIS_TVALID = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_remaining <= 10'd0;
            r_gap_cnt   <= 8'd0;
            r_tdata     <= '0;
        end else begin
            if ((r_state == S_CNT_R) && M_AXI_RVALID && !w_cnt_empty) begin
                r_remaining <= w_burst;
            end else if (w_consume && (r_remaining != 10'd0)) begin
                r_remaining <= r_remaining - 10'd1;
            end

            if ((r_state == S_CNT_R) && M_AXI_RVALID && w_cnt_empty) begin
                r_gap_cnt <= GAP_LOAD;
            end else if ((r_state == S_GAP) && (r_gap_cnt != 8'd0)) begin
                r_gap_cnt <= r_gap_cnt - 8'd1;
            end

            if ((r_state == S_DAT_R) && M_AXI_RVALID && w_r_ok) begin
                r_tdata <= M_AXI_RDATA;
            end
        end
    end

    assign M_AXIS_TDATA = r_tdata;

`ifdef AXIL_STREAM_READER_ERR_COUNT_EN
    logic [15:0] r_err_count;
    logic        w_err_hit;

    assign w_err_hit = M_AXI_RVALID && !w_r_ok &&
                       ((r_state == S_CNT_R) || (r_state == S_DAT_R));

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_err_count <= 16'd0;
        end else if (w_err_hit && (r_err_count != 16'hFFFF)) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_axil_stream_reader.sv
// Bench for axil_stream_reader: scripted and random AXI4-Lite slave, transaction-level
// expectations for addresses, stream words, gap length and throughput.
module tb_axil_stream_reader;

    localparam int DW   = 32;
    localparam int AW   = 4;
    localparam int BASE = 0;
    localparam int MAXB = 16;
    localparam int GAP  = 8;
    localparam logic [AW-1:0] A_DAT = AW'(BASE);
    localparam logic [AW-1:0] A_CNT = AW'(BASE + 4);

    typedef struct packed { logic [31:0] d; logic [1:0] r; } rsp_t;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;
    logic          tvalid;
    logic [DW-1:0] tdata;
    logic          tready;
    logic          busy;
`ifdef AXIL_STREAM_READER_ERR_COUNT_EN
    logic [15:0]   err_count;
    int            err_model = 0;
`endif

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    rsp_t cnt_q[$];
    rsp_t dat_q[$];
    logic [31:0] exp_q[$];
    int   hs_q[$];
    int   n_cnt_reads = 0, n_dat_reads = 0, n_words = 0, gap_checks = 0;
    int   exp_dat_reads = 0;
    bit   gap_pending = 0, en_low = 0;
    int   gap_t0 = 0;
    int   err_pct = 0, dly_max = 0, tr_mode = 0;
    bit   ar_block = 0;

    axil_stream_reader #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE),
        .MAX_BURST(MAXB), .POLL_GAP(GAP)
    ) dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESETN(rst_n),
        .enable       (enable),
        .M_AXI_ARADDR (araddr),
        .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA  (rdata),
        .M_AXI_RRESP  (rresp),
        .M_AXI_RVALID (rvalid),
        .M_AXI_RREADY (rready),
        .M_AXIS_TVALID(tvalid),
        .M_AXIS_TDATA (tdata),
        .M_AXIS_TREADY(tready),
`ifdef AXIL_STREAM_READER_ERR_COUNT_EN
        .err_count    (err_count),
`endif
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic logic [1:0] rand_resp();
        if (int'($urandom_range(99, 0)) < err_pct) return 2'($urandom_range(3, 1));
        return 2'b00;
    endfunction

    // AXI4-Lite slave: one outstanding read, random or scripted delays and responses.
    // Expected address order and stream contents follow from the responses it hands out.
    initial begin : slave
        int sp, ar_cnt, r_cnt, lo;
        logic [AW-1:0] ar_addr;
        logic [31:0]   rd;
        logic [1:0]    rr;
        bit            is_cnt;
        rsp_t          e;
        sp = 0; ar_cnt = -1; r_cnt = 0; lo = 0; ar_addr = '0; rd = '0; rr = '0; is_cnt = 0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                arready = 1'b0; rvalid = 1'b0; sp = 0; ar_cnt = -1;
                exp_dat_reads = 0; gap_pending = 0;
`ifdef AXIL_STREAM_READER_ERR_COUNT_EN
                err_model = 0;
`endif
            end else begin
                if (gap_pending && !enable) en_low = 1;
                if (sp == 4) begin rvalid = 1'b0; sp = 0; end
                if (sp == 1) begin
                    arready = 1'b0;
                    is_cnt  = (ar_addr == A_CNT);
                    if (is_cnt && cnt_q.size() > 0) begin
                        e = cnt_q.pop_front(); rd = e.d; rr = e.r;
                    end else if (is_cnt) begin
                        lo = ($urandom_range(7, 0) == 0) ? 1023 : int'($urandom_range(40, 0));
                        rd = $urandom; rd[9:0] = 10'(lo); rr = rand_resp();
                    end else if (dat_q.size() > 0) begin
                        e = dat_q.pop_front(); rd = e.d; rr = e.r;
                    end else begin
                        rd = $urandom; rr = rand_resp();
                    end
                    r_cnt = int'($urandom_range(dly_max, 0));
                    sp = 2;
                end
                if (sp == 2) begin
                    if (r_cnt == 0) begin rvalid = 1'b1; rdata = rd; rresp = rr; sp = 3; end
                    else r_cnt--;
                end
                if (sp == 3 && rready) begin
`ifdef AXIL_STREAM_READER_ERR_COUNT_EN
                    if (rr != 2'b00 && err_model < 65535) err_model++;
`endif
                    if (is_cnt) begin
                        if (rr != 2'b00 || rd[9:0] == 10'd0) begin
                            gap_pending = 1; en_low = 0; gap_t0 = cyc + 1; exp_dat_reads = 0;
                        end else begin
                            lo = int'(rd[9:0]);
                            exp_dat_reads = (lo > MAXB) ? MAXB : lo;
                        end
                    end else if (rr == 2'b00) begin
                        exp_q.push_back(rd);
                    end
                    sp = 4;
                end
                if (sp == 0) begin
                    if (ar_cnt >= 0) begin
                        check_val("arvalid_hold", 32'(arvalid), 32'd1);
                        check_val("araddr_hold", 32'(araddr), 32'(ar_addr));
                        if (!arvalid) ar_cnt = -1;
                    end else if (arvalid) begin
                        ar_addr = araddr;
                        if (gap_pending) begin
                            // POLL_GAP cycles in GAP, one in IDLE, then the address phase
                            if (!en_low) begin
                                check_val("gap_len", 32'(cyc - gap_t0), 32'(GAP + 1));
                                gap_checks++;
                            end
                            gap_pending = 0;
                        end
                        ar_cnt = int'($urandom_range(dly_max, 0));
                    end
                    if (ar_cnt >= 0 && !ar_block) begin
                        if (ar_cnt == 0) begin
                            arready = 1'b1;
                            if (exp_dat_reads > 0) begin
                                check_val("araddr_dat", 32'(ar_addr), 32'(A_DAT));
                                exp_dat_reads--; n_dat_reads++;
                            end else begin
                                check_val("araddr_cnt", 32'(ar_addr), 32'(A_CNT));
                                n_cnt_reads++;
                            end
                            ar_cnt = -1; sp = 1;
                        end else begin
                            ar_cnt--;
                        end
                    end
                end
            end
        end
    end

    // Stream sink: drives TREADY, checks words against the expected queue and hold behaviour
    initial begin : mon
        bit          stall;
        logic [31:0] held;
        stall = 0; held = '0; tready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete(); stall = 0; tready = 1'b0;
            end else begin
                if (stall) begin
                    check_val("tvalid_hold", 32'(tvalid), 32'd1);
                    check_val("tdata_hold", tdata, held);
                end
                case (tr_mode)
                    0:       tready = 1'b1;
                    1:       tready = 1'($urandom_range(1, 0));
                    default: tready = 1'b0;
                endcase
                if (tvalid && tready) begin
                    if (exp_q.size() == 0) check_val("stream_extra", 32'(exp_q.size()), 32'd1);
                    else check_val("stream_data", tdata, exp_q.pop_front());
                    n_words++;
                    hs_q.push_back(cyc + 1);
                end
                stall = tvalid && !tready;
                held  = tdata;
            end
        end
    end

    task automatic wait_idle(input string tag, input int bound);
        int k = 0;
        do begin @(negedge clk); k++; end while (busy && k < bound);
        check_val({tag, "_idle"}, 32'(busy), 32'd0);
        check_val({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_cnt_reads(input string tag, input int target, input int bound);
        int k = 0;
        do begin @(negedge clk); k++; end while (n_cnt_reads < target && k < bound);
        check_val({tag, "_polls"}, 32'(n_cnt_reads >= target), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_arvalid"}, 32'(arvalid), 32'd0);
        check_val({tag, "_araddr"}, 32'(araddr), 32'd0);
        check_val({tag, "_rready"}, 32'(rready), 32'd0);
        check_val({tag, "_tvalid"}, 32'(tvalid), 32'd0);
        check_val({tag, "_tdata"}, tdata, 32'd0);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int w0, d0, c0, gc0, k;
`ifdef AXIL_STREAM_READER_ERR_COUNT_EN
        int e0;
`endif
        rst_n = 1'b0; enable = 1'b0;
        #3;
        check_reset_outputs("rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // three-word burst, enable dropped once the poll is under way
        cnt_q.push_back('{32'd3, 2'b00});
        dat_q.push_back('{32'hA1, 2'b00});
        dat_q.push_back('{32'hA2, 2'b00});
        dat_q.push_back('{32'hA3, 2'b00});
        hs_q.delete(); w0 = n_words; d0 = n_dat_reads;
        @(negedge clk); enable = 1'b1;
        check_val("t1_arvalid_pre", 32'(arvalid), 32'd0);
        @(negedge clk);
        check_val("t1_arvalid_rise", 32'(arvalid), 32'd1);
        check_val("t1_araddr", 32'(araddr), 32'(A_CNT));
        check_val("t1_busy", 32'(busy), 32'd1);
        enable = 1'b0;
        wait_idle("t1", 200);
        check_val("t1_words", 32'(n_words - w0), 32'd3);
        check_val("t1_dreads", 32'(n_dat_reads - d0), 32'd3);
        check_val("t1_rate", 32'((hs_q.size() >= 3) ? hs_q[2] - hs_q[0] : -1), 32'd6);

        // empty FIFO: gap, then a fresh count poll
        cnt_q.push_back('{32'd0, 2'b00});
        cnt_q.push_back('{32'd1, 2'b00});
        dat_q.push_back('{32'h55, 2'b00});
        c0 = n_cnt_reads; gc0 = gap_checks; w0 = n_words;
        enable = 1'b1;
        wait_cnt_reads("t2", c0 + 2, 300);
        enable = 1'b0;
        wait_idle("t2", 200);
        check_val("t2_gapchk", 32'(gap_checks - gc0), 32'd1);
        check_val("t2_words", 32'(n_words - w0), 32'd1);

        // count above MAX_BURST, with upper count bits set
        cnt_q.push_back('{32'hFFFF_FC28, 2'b00});
        cnt_q.push_back('{32'd0, 2'b00});
        dly_max = 2;
        c0 = n_cnt_reads; d0 = n_dat_reads; w0 = n_words;
        enable = 1'b1;
        wait_cnt_reads("t3", c0 + 2, 600);
        check_val("t3_dreads", 32'(n_dat_reads - d0), 32'(MAXB));
        enable = 1'b0;
        wait_idle("t3", 200);
        check_val("t3_words", 32'(n_words - w0), 32'(MAXB));
        dly_max = 0;

        // back-pressure in OUT
        cnt_q.push_back('{32'd2, 2'b00});
        dat_q.push_back('{32'h11, 2'b00});
        dat_q.push_back('{32'h22, 2'b00});
        tr_mode = 2; w0 = n_words;
        enable = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!tvalid && k < 100);
        check_val("t4_tvalid", 32'(tvalid), 32'd1);
        enable = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_val("t4_tdata", tdata, 32'h11);
            check_val("t4_no_ar", 32'(arvalid), 32'd0);
        end
        tr_mode = 0;
        wait_idle("t4", 200);
        check_val("t4_words", 32'(n_words - w0), 32'd2);

        // error response on the second data read
        cnt_q.push_back('{32'd3, 2'b00});
        dat_q.push_back('{32'hA1, 2'b00});
        dat_q.push_back('{32'hB2, 2'b10});
        dat_q.push_back('{32'hA3, 2'b00});
        c0 = n_cnt_reads; d0 = n_dat_reads; w0 = n_words;
`ifdef AXIL_STREAM_READER_ERR_COUNT_EN
        e0 = int'(err_count);
`endif
        enable = 1'b1;
        wait_cnt_reads("t5", c0 + 1, 100);
        enable = 1'b0;
        wait_idle("t5", 200);
        check_val("t5_words", 32'(n_words - w0), 32'd2);
        check_val("t5_dreads", 32'(n_dat_reads - d0), 32'd3);
`ifdef AXIL_STREAM_READER_ERR_COUNT_EN
        check_val("t5_errcnt", 32'(err_count), 32'(e0 + 1));
`endif

        // reset while the address phase is stalled
        ar_block = 1;
        enable = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!arvalid && k < 50);
        check_val("t7_arvalid", 32'(arvalid), 32'd1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("t7_rst");
        ar_block = 0;
        cnt_q.delete(); dat_q.delete();
        cnt_q.push_back('{32'd0, 2'b00});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("t7_repoll", 32'(arvalid), 32'd1);
        check_val("t7_repoll_addr", 32'(araddr), 32'(A_CNT));
        enable = 1'b0;
        wait_idle("t7", 200);

        // random traffic: delays, error responses, random TREADY
        err_pct = 15; dly_max = 3; tr_mode = 1;
        c0 = n_cnt_reads;
        enable = 1'b1;
        wait_cnt_reads("t8", c0 + 25, 20000);
        enable = 1'b0;
        wait_idle("t8", 2000);
`ifdef AXIL_STREAM_READER_ERR_COUNT_EN
        check_val("t8_errcnt", 32'(err_count), 32'(err_model));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axil_stream_reader.md
AXIL_STREAM_READER -- requirements
Module: axil_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32: AXI4-Lite read data width and AXI-Stream TDATA width.
REQ-002 Parameter ADDR_WIDTH, default 4: AXI4-Lite address width.
REQ-003 Parameter BASE_ADDR, default 0: base address of the remote FIFO register window; data register at +0x0, read-count register at +0x4.
REQ-004 Parameter MAX_BURST, default 16, range 1..1023: maximum data reads per poll.
REQ-005 Parameter POLL_GAP, default 8, range 1..255: idle cycles after an empty or failed poll.
REQ-006 Clock and reset: one clock and an asynchronous active-low reset, named M_AXI_ACLK and M_AXI_ARESETN.
REQ-007 M_AXI_ACLK  in  1  clock for all logic.
REQ-008 M_AXI_ARESETN  in  1  asynchronous active-low reset.
REQ-009 enable  in  1  permits new polls; sampled only in IDLE.
REQ-010 M_AXI_ARADDR  out  ADDR_WIDTH  read address.
REQ-011 M_AXI_ARVALID  out  1  read address valid.
REQ-012 M_AXI_ARREADY  in  1  read address accepted.
REQ-013 M_AXI_RDATA  in  DATA_WIDTH  read data.
REQ-014 M_AXI_RRESP  in  2  read response; 2'b00 is OKAY, any other value is an error.
REQ-015 M_AXI_RVALID  in  1  read data valid.
REQ-016 M_AXI_RREADY  out  1  read data accepted.
REQ-017 M_AXIS_TVALID  out  1  stream word valid.
REQ-018 M_AXIS_TDATA  out  DATA_WIDTH  stream word.
REQ-019 M_AXIS_TREADY  in  1  downstream accepts the word.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 The FSM SHALL use states IDLE, CNT_AR, CNT_R, DAT_AR, DAT_R, OUT and GAP.
REQ-022 IDLE: enable=1 -> CNT_AR on the next cycle, so ARVALID rises 1 cycle after enable is sampled high.
REQ-023 CNT_AR: ARVALID=1 and ARADDR=BASE_ADDR+4; on ARREADY -> CNT_R.
REQ-024 CNT_R: RREADY=1; on RVALID with RRESP!=0 or RDATA[9:0]==0 -> GAP; otherwise remaining=min(RDATA[9:0],MAX_BURST) -> DAT_AR.
REQ-025 DAT_AR: ARVALID=1 and ARADDR=BASE_ADDR+0; on ARREADY -> DAT_R.
REQ-026 DAT_R: RREADY=1; on RVALID with RRESP==0, register RDATA into TDATA, assert TVALID -> OUT.
REQ-027 DAT_R error: on RVALID with RRESP!=0, drop the word, decrement remaining, then go to DAT_AR if remaining>0, else IDLE.
REQ-028 OUT: hold TVALID and TDATA stable until TREADY; on TREADY, decrement remaining, then go to DAT_AR if remaining>0, else IDLE.
REQ-029 GAP: count POLL_GAP cycles, then -> IDLE.
REQ-030 ARVALID SHALL never deassert and ARADDR SHALL never change before ARREADY; at most one read is outstanding; RREADY is low outside CNT_R and DAT_R.
REQ-031 enable deasserted mid-burst SHALL NOT abort the burst; the current burst always completes.
REQ-032 Minimum throughput SHALL be 1 word per 3 cycles (ARREADY immediate, RVALID next cycle, TREADY held high).
REQ-033 remaining SHALL be 10 bits wide and SHALL never underflow.

Reset
REQ-034 M_AXI_ARESETN low SHALL asynchronously force state=IDLE, ARVALID=0, RREADY=0, TVALID=0, TDATA=0, ARADDR=0, busy=0, remaining=0 and the gap counter to 0.
REQ-035 Reset in any state, including mid-handshake, SHALL discard the burst; after release the block restarts from IDLE.

Configuration
REQ-036 With macro AXIL_STREAM_READER_ERR_COUNT_EN defined, the block SHALL add output err_count (16 bits, reset 0) that increments on every non-OKAY RRESP in CNT_R or DAT_R and saturates at 0xFFFF.
REQ-037 Without AXIL_STREAM_READER_ERR_COUNT_EN, port err_count and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-038 Count read returns 3 with OKAY, data 0xA1,0xA2,0xA3, TREADY=1 -> ARADDR sequence 0x4,0x0,0x0,0x0; TDATA A1,A2,A3; return to IDLE.
REQ-039 Count read returns 0 -> GAP for exactly 8 cycles, then a new poll at ARADDR 0x4 while enable=1.
REQ-040 Count read returns 40 with MAX_BURST=16 -> exactly 16 data reads, then a new count poll.
REQ-041 TREADY low for 5 cycles in OUT -> TDATA stable, no new ARVALID until the TREADY handshake.
REQ-042 Second data read returns RRESP=2'b10 with count 3 -> 2 words emitted; with AXIL_STREAM_READER_ERR_COUNT_EN, err_count=1.
REQ-043 Reset asserted while ARVALID=1 and ARREADY=0 -> ARVALID drops immediately; first poll follows release with enable=1.
